// File: rtl/prog_mem_arbiter.sv
// -----------------------------------------------------------------------------
// prog_mem_arbiter
//
// Shares the single program-memory read port between the instruction fetchers
// of all cores. Each fetcher issues a level-held valid/ready read request. The
// arbiter grants one request at a time in round-robin order, forwards it to
// program memory and returns the fetched instruction to the granted fetcher.
// Only one grant is outstanding at any time.
//
// Parameters:
//   NUM_CONSUMERS  number of fetchers sharing the port (>= 1)
//   ADDR_BITS      program memory address width
//   DATA_BITS      instruction width
//
// Ports:
//   clk                    system clock, rising edge
//   reset                  synchronous, active-high reset
//   consumer_read_valid    per-fetcher request, held until ready is seen
//   consumer_read_address  per-fetcher PC, stable while valid
//   consumer_read_ready    per-fetcher response strobe (at most one high)
//   consumer_read_data     per-fetcher instruction, holds until next grant
//   mem_read_valid         request to program memory
//   mem_read_address       address to program memory
//   mem_read_ready         program memory response strobe
//   mem_read_data          program memory instruction
//
// Optional feature:
//   PROG_ARB_LAST_FETCH_CACHE_EN  when defined, a one-entry cache of the most
//   recent memory response lets a repeat fetch of the same address skip the
//   memory round trip.
// -----------------------------------------------------------------------------
module prog_mem_arbiter #(
  parameter int unsigned NUM_CONSUMERS = 4,
  parameter int unsigned ADDR_BITS     = 8,
  parameter int unsigned DATA_BITS     = 16
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  output logic                                    mem_read_valid,
  output logic [ADDR_BITS-1:0]                    mem_read_address,
  input  logic                                    mem_read_ready,
  input  logic [DATA_BITS-1:0]                    mem_read_data
);

  localparam int unsigned IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAITING  = 2'd1,
    RELAYING = 2'd2
  } state_t;

  state_t                                  state, state_n;
  logic [IDX_BITS-1:0]                     grant, grant_n;
  logic [IDX_BITS-1:0]                     last_grant, last_grant_n;
  logic                                    mem_valid_n;
  logic [ADDR_BITS-1:0]                    mem_addr_n;
  logic [NUM_CONSUMERS-1:0]                ready_n;
  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] data_n;

`ifdef PROG_ARB_LAST_FETCH_CACHE_EN
  logic                 cache_valid, cache_valid_n;
  logic [ADDR_BITS-1:0] cache_addr,  cache_addr_n;
  logic [DATA_BITS-1:0] cache_data,  cache_data_n;
`endif

  // Round-robin scan: first requester at or after last_grant+1, wrapping.
  logic                found;
  logic [IDX_BITS-1:0] pick;
  logic [IDX_BITS-1:0] cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_CONSUMERS; k++) begin
      cand = IDX_BITS'((32'(last_grant) + 32'd1 + k) % NUM_CONSUMERS);
      if (!found && consumer_read_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_grant_n = last_grant;
    mem_valid_n  = mem_read_valid;
    mem_addr_n   = mem_read_address;
    ready_n      = consumer_read_ready;
    data_n       = consumer_read_data;
`ifdef PROG_ARB_LAST_FETCH_CACHE_EN
    cache_valid_n = cache_valid;
    cache_addr_n  = cache_addr;
    cache_data_n  = cache_data;
`endif

    unique case (state)
      IDLE: begin
        if (found) begin
          grant_n      = pick;
          last_grant_n = pick;
`ifdef PROG_ARB_LAST_FETCH_CACHE_EN
          if (cache_valid && (consumer_read_address[pick] == cache_addr)) begin
            // Hit: answer straight from the cache, memory never sees it.
            data_n[pick]  = cache_data;
            ready_n[pick] = 1'b1;
            state_n       = RELAYING;
          end else begin
            mem_valid_n = 1'b1;
            mem_addr_n  = consumer_read_address[pick];
            state_n     = WAITING;
          end
`else
          mem_valid_n = 1'b1;
          mem_addr_n  = consumer_read_address[pick];
          state_n     = WAITING;
`endif
        end
      end

      WAITING: begin
        if (mem_read_ready) begin
          mem_valid_n    = 1'b0;
          data_n[grant]  = mem_read_data;
          ready_n[grant] = 1'b1;
          state_n        = RELAYING;
`ifdef PROG_ARB_LAST_FETCH_CACHE_EN
          cache_valid_n = 1'b1;
          cache_addr_n  = mem_read_address;
          cache_data_n  = mem_read_data;
`endif
        end
      end

      RELAYING: begin
        // Wait for the fetcher to drop its request so one fetch is served once.
        if (!consumer_read_valid[grant]) begin
          ready_n = '0;
          state_n = IDLE;
        end
      end

      default: begin
        ready_n     = '0;
        mem_valid_n = 1'b0;
        state_n     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      grant               <= '0;
      last_grant          <= IDX_BITS'(NUM_CONSUMERS - 1);
      mem_read_valid      <= 1'b0;
      mem_read_address    <= '0;
      consumer_read_ready <= '0;
      consumer_read_data  <= '0;
`ifdef PROG_ARB_LAST_FETCH_CACHE_EN
      cache_valid         <= 1'b0;
      cache_addr          <= '0;
      cache_data          <= '0;
`endif
    end else begin
      state               <= state_n;
      grant               <= grant_n;
      last_grant          <= last_grant_n;
      mem_read_valid      <= mem_valid_n;
      mem_read_address    <= mem_addr_n;
      consumer_read_ready <= ready_n;
      consumer_read_data  <= data_n;
`ifdef PROG_ARB_LAST_FETCH_CACHE_EN
      cache_valid         <= cache_valid_n;
      cache_addr          <= cache_addr_n;
      cache_data          <= cache_data_n;
`endif
    end
  end

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_prog_mem_arbiter
//
// Directed self-checking bench for prog_mem_arbiter (4 consumers, 8-bit
// address, 16-bit data). A simple program-memory responder answers each
// request a fixed number of cycles after mem_read_valid rises. Cache checks
// follow PROG_ARB_LAST_FETCH_CACHE_EN.
// -----------------------------------------------------------------------------
module tb_prog_mem_arbiter;

  localparam int N       = 4;
  localparam int AW      = 8;
  localparam int DW      = 16;
  localparam int MEM_LAT = 3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [N-1:0]         consumer_read_valid = '0;
  logic [N-1:0][AW-1:0] consumer_read_address = '0;
  logic [N-1:0]         consumer_read_ready;
  logic [N-1:0][DW-1:0] consumer_read_data;
  logic                 mem_read_valid;
  logic [AW-1:0]        mem_read_address;
  logic                 mem_read_ready = 1'b0;
  logic [DW-1:0]        mem_read_data = '0;

  prog_mem_arbiter #(
    .NUM_CONSUMERS(N),
    .ADDR_BITS    (AW),
    .DATA_BITS    (DW)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .consumer_read_valid  (consumer_read_valid),
    .consumer_read_address(consumer_read_address),
    .consumer_read_ready  (consumer_read_ready),
    .consumer_read_data   (consumer_read_data),
    .mem_read_valid       (mem_read_valid),
    .mem_read_address     (mem_read_address),
    .mem_read_ready       (mem_read_ready),
    .mem_read_data        (mem_read_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int            mem_req_cnt = 0;
  int            overlap_err = 0;
  int            multi_ready_err = 0;
  logic [AW-1:0] req_addr_q[$];
  int            ready_q[$];
  logic          prev_mvalid = 1'b0;
  logic [N-1:0]  prev_ready = '0;
  bit            mem_auto = 1'b1;
  int            mem_cnt = 0;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    case (a)
      8'h05:   return 16'h1234;
      8'h10:   return 16'hABCD;
      default: return {a, ~a};
    endcase
  endfunction

  // One clock: observe outputs just after the edge, then let memory respond.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_read_valid && !prev_mvalid) begin
      mem_req_cnt++;
      req_addr_q.push_back(mem_read_address);
    end
    if (mem_read_valid && (consumer_read_ready != '0)) overlap_err++;
    if ($countones(consumer_read_ready) > 1) multi_ready_err++;
    for (int i = 0; i < N; i++)
      if (consumer_read_ready[i] && !prev_ready[i]) ready_q.push_back(i);
    prev_mvalid = mem_read_valid;
    prev_ready  = consumer_read_ready;
    if (mem_auto) begin
      if (reset) begin
        mem_cnt        = 0;
        mem_read_ready = 1'b0;
      end else if (mem_read_ready) begin
        mem_read_ready = 1'b0;
      end else if (mem_read_valid) begin
        mem_cnt++;
        if (mem_cnt == MEM_LAT) begin
          mem_read_ready = 1'b1;
          mem_read_data  = mem_fn(mem_read_address);
          mem_cnt        = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic clear_obs();
    mem_req_cnt = 0;
    req_addr_q.delete();
    ready_q.delete();
  endtask

  task automatic wait_ready(input int i, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    repeat (40) begin
      tick();
      cycles++;
      if (consumer_read_ready[i]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_read_valid !== 1'b0) begin failures++; $display("FAIL reset_mvalid got=%b exp=0", mem_read_valid); end
    checks++; if (mem_read_address !== 8'h00) begin failures++; $display("FAIL reset_maddr got=%h exp=00", mem_read_address); end
    checks++; if (consumer_read_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", consumer_read_ready); end
    checks++; if (consumer_read_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", consumer_read_data); end
  endtask

  task automatic test_single();
    int cyc;
    bit ok;
    clear_obs();
    consumer_read_address[2] = 8'h05;
    consumer_read_valid[2]   = 1'b1;
    tick();
    checks++; if (mem_read_valid !== 1'b1) begin failures++; $display("FAIL single_mvalid got=%b exp=1", mem_read_valid); end
    checks++; if (mem_read_address !== 8'h05) begin failures++; $display("FAIL single_maddr got=%h exp=05", mem_read_address); end
    wait_ready(2, cyc, ok);
    checks++; if (!ok || cyc != MEM_LAT) begin failures++; $display("FAIL single_latency got=%0d ok=%0d exp=%0d", cyc, ok, MEM_LAT); end
    checks++; if (consumer_read_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", consumer_read_ready); end
    checks++; if (consumer_read_data[2] !== 16'h1234) begin failures++; $display("FAIL single_data got=%h exp=1234", consumer_read_data[2]); end
    checks++; if (mem_read_valid !== 1'b0) begin failures++; $display("FAIL single_mvalid_low got=%b exp=0", mem_read_valid); end
    consumer_read_valid[2] = 1'b0;
    tick();
    checks++; if (consumer_read_ready !== 4'b0000) begin failures++; $display("FAIL single_ready_drop got=%b exp=0000", consumer_read_ready); end
    repeat (4) tick();
    checks++; if (consumer_read_data[2] !== 16'h1234) begin failures++; $display("FAIL single_data_hold got=%h exp=1234", consumer_read_data[2]); end
    checks++; if (mem_req_cnt != 1) begin failures++; $display("FAIL single_req_count got=%0d exp=1", mem_req_cnt); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit ok;
    clear_obs();
    consumer_read_address[1] = 8'h22;
    consumer_read_valid[1]   = 1'b1;
    wait_ready(1, cyc, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=no_ready exp=ready"); end
    tick();
    checks++; if (consumer_read_ready !== 4'b0010) begin failures++; $display("FAIL b2b_ready_hold got=%b exp=0010", consumer_read_ready); end
    consumer_read_valid[1] = 1'b0;
    tick();
    checks++; if (consumer_read_ready !== 4'b0000) begin failures++; $display("FAIL b2b_ready_drop got=%b exp=0000", consumer_read_ready); end
    checks++; if (consumer_read_data[1] !== 16'h22DD) begin failures++; $display("FAIL b2b_data got=%h exp=22dd", consumer_read_data[1]); end
    repeat (4) tick();
    checks++; if (mem_req_cnt != 1) begin failures++; $display("FAIL b2b_req_count got=%0d exp=1", mem_req_cnt); end
  endtask

  task automatic test_round_robin();
    int            served[N];
    int            want[N];
    int            exp_order[5];
    logic [AW-1:0] exp_addr[5];
    exp_order = '{0, 1, 2, 3, 0};
    exp_addr  = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h40};
    want      = '{2, 1, 1, 1};
    for (int i = 0; i < N; i++) begin
      served[i] = 0;
      consumer_read_address[i] = AW'(8'h40 + i);
    end
    consumer_read_valid = '1;
    overlap_err = 0;
    multi_ready_err = 0;
    do_reset();
    clear_obs();
    repeat (200) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (consumer_read_valid[i] && consumer_read_ready[i]) begin
          consumer_read_valid[i] = 1'b0;
          served[i]++;
        end else if (!consumer_read_valid[i] && served[i] < want[i]) begin
          consumer_read_valid[i] = 1'b1;
        end
      end
      if (ready_q.size() >= 5) break;
    end
    repeat (4) tick();
    checks++; if (ready_q.size() != 5) begin failures++; $display("FAIL rr_grant_count got=%0d exp=5", ready_q.size()); end
    for (int k = 0; k < 5; k++) begin
      if (k < ready_q.size()) begin
        checks++; if (ready_q[k] != exp_order[k]) begin failures++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, ready_q[k], exp_order[k]); end
      end
      if (k < req_addr_q.size()) begin
        checks++; if (req_addr_q[k] !== exp_addr[k]) begin failures++; $display("FAIL rr_addr[%0d] got=%h exp=%h", k, req_addr_q[k], exp_addr[k]); end
      end
    end
    checks++; if (mem_req_cnt != 5) begin failures++; $display("FAIL rr_req_count got=%0d exp=5", mem_req_cnt); end
    checks++; if (overlap_err != 0) begin failures++; $display("FAIL rr_overlap got=%0d exp=0", overlap_err); end
    checks++; if (multi_ready_err != 0) begin failures++; $display("FAIL rr_multi_ready got=%0d exp=0", multi_ready_err); end
  endtask

  task automatic test_reset_waiting();
    mem_auto = 1'b0;
    mem_read_ready = 1'b0;
    clear_obs();
    consumer_read_address[2] = 8'h33;
    consumer_read_valid[2]   = 1'b1;
    tick();
    checks++; if (mem_read_valid !== 1'b1) begin failures++; $display("FAIL rstw_mvalid got=%b exp=1", mem_read_valid); end
    tick();
    tick();
    reset = 1'b1;
    consumer_read_valid = '0;
    tick();
    reset = 1'b0;
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hDEAD;
    tick();
    mem_read_ready = 1'b0;
    tick();
    tick();
    checks++; if (mem_read_valid !== 1'b0) begin failures++; $display("FAIL rstw_mvalid_low got=%b exp=0", mem_read_valid); end
    checks++; if (mem_read_address !== 8'h00) begin failures++; $display("FAIL rstw_maddr got=%h exp=00", mem_read_address); end
    checks++; if (consumer_read_ready !== 4'b0000) begin failures++; $display("FAIL rstw_ready got=%b exp=0000", consumer_read_ready); end
    checks++; if (consumer_read_data !== '0) begin failures++; $display("FAIL rstw_data got=%h exp=0", consumer_read_data); end
    checks++; if (ready_q.size() != 0) begin failures++; $display("FAIL rstw_ready_events got=%0d exp=0", ready_q.size()); end
    mem_cnt  = 0;
    mem_auto = 1'b1;
  endtask

  task automatic test_cache_hit();
    int cyc;
    bit ok;
    do_reset();
    consumer_read_address[0] = 8'h10;
    consumer_read_valid[0]   = 1'b1;
    wait_ready(0, cyc, ok);
    checks++; if (!ok || consumer_read_data[0] !== 16'hABCD) begin failures++; $display("FAIL cache_first got=%h ok=%0d exp=abcd", consumer_read_data[0], ok); end
    consumer_read_valid[0] = 1'b0;
    tick();
    tick();
    clear_obs();
    consumer_read_address[3] = 8'h10;
    consumer_read_valid[3]   = 1'b1;
    tick();
`ifdef PROG_ARB_LAST_FETCH_CACHE_EN
    checks++; if (consumer_read_ready !== 4'b1000) begin failures++; $display("FAIL cache_hit_ready got=%b exp=1000", consumer_read_ready); end
    checks++; if (consumer_read_data[3] !== 16'hABCD) begin failures++; $display("FAIL cache_hit_data got=%h exp=abcd", consumer_read_data[3]); end
    checks++; if (mem_read_valid !== 1'b0) begin failures++; $display("FAIL cache_hit_mvalid got=%b exp=0", mem_read_valid); end
`else
    checks++; if (mem_read_valid !== 1'b1) begin failures++; $display("FAIL nocache_mvalid got=%b exp=1", mem_read_valid); end
    checks++; if (consumer_read_ready !== 4'b0000) begin failures++; $display("FAIL nocache_ready got=%b exp=0000", consumer_read_ready); end
    wait_ready(3, cyc, ok);
    checks++; if (!ok || consumer_read_data[3] !== 16'hABCD) begin failures++; $display("FAIL nocache_data got=%h ok=%0d exp=abcd", consumer_read_data[3], ok); end
`endif
    consumer_read_valid[3] = 1'b0;
    tick();
    tick();
`ifdef PROG_ARB_LAST_FETCH_CACHE_EN
    checks++; if (mem_req_cnt != 0) begin failures++; $display("FAIL cache_req_count got=%0d exp=0", mem_req_cnt); end
`else
    checks++; if (mem_req_cnt != 1) begin failures++; $display("FAIL cache_req_count got=%0d exp=1", mem_req_cnt); end
`endif
  endtask

  task automatic test_cache_invalidate();
    int cyc;
    bit ok;
    do_reset();
    clear_obs();
    consumer_read_address[0] = 8'h10;
    consumer_read_valid[0]   = 1'b1;
    tick();
    checks++; if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h10) begin failures++; $display("FAIL inval_mreq got=%b/%h exp=1/10", mem_read_valid, mem_read_address); end
    wait_ready(0, cyc, ok);
    checks++; if (!ok || consumer_read_data[0] !== 16'hABCD) begin failures++; $display("FAIL inval_data got=%h ok=%0d exp=abcd", consumer_read_data[0], ok); end
    consumer_read_valid[0] = 1'b0;
    tick();
    checks++; if (mem_req_cnt != 1) begin failures++; $display("FAIL inval_req_count got=%0d exp=1", mem_req_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_round_robin();
    test_reset_waiting();
    test_cache_hit();
    test_cache_invalidate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_mem_arbiter.md
# prog_mem_arbiter

Shares the single program-memory read port between the instruction fetchers of all cores. Each fetcher issues a level-held valid/ready read request. The arbiter grants one request at a time in round-robin order, forwards it to program memory, and returns the fetched instruction to the granted fetcher. It sits between the per-core fetchers and the program memory controller port in the GPU top level.

## Interface
- `NUM_CONSUMERS`, default 4: number of fetchers (cores) sharing the port; must be ≥ 1.
- `ADDR_BITS`, default 8: program memory address width.
- `DATA_BITS`, default 16: instruction width.

- `clk`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `consumer_read_valid`  input  [NUM_CONSUMERS]  per-fetcher request; held high until that fetcher sees ready.
- `consumer_read_address`  input  [NUM_CONSUMERS][ADDR_BITS]  per-fetcher PC; stable while valid.
- `consumer_read_ready`  output  [NUM_CONSUMERS]  per-fetcher response strobe.
- `consumer_read_data`  output  [NUM_CONSUMERS][DATA_BITS]  per-fetcher instruction; valid while ready is high.
- `mem_read_valid`  output  1  request to program memory.
- `mem_read_address`  output  ADDR_BITS  address to program memory.
- `mem_read_ready`  input  1  program memory response strobe.
- `mem_read_data`  input  DATA_BITS  program memory instruction.

## Operation
- There are three states, encoded as 2 bits: IDLE, WAITING, RELAYING. At most one grant is outstanding.
- **IDLE:**
  - Scan `consumer_read_valid` starting at `last_grant+1` mod `NUM_CONSUMERS`, wrapping around. The first set bit is the grant `g`.
  - With no requester, stay in IDLE.
  - On a grant, register `g`, set `last_grant <= g`, drive `mem_read_valid <= 1` and `mem_read_address <= consumer_read_address[g]`, and go to WAITING.
- **WAITING:**
  - Hold `mem_read_valid` and the address until `mem_read_ready` is sampled high.
  - Then set `mem_read_valid <= 0`, `consumer_read_data[g] <= mem_read_data`, `consumer_read_ready[g] <= 1`, and go to RELAYING.
- **RELAYING:**
  - Hold `consumer_read_ready[g]` high until `consumer_read_valid[g]` is sampled low.
  - Then set `consumer_read_ready[g] <= 0` and go to IDLE.
  - This prevents serving the same fetch twice.
- `consumer_read_data[i]` holds its last value until it is overwritten by the next grant to `i`.
- Only `consumer_read_ready[g]` is ever high; all other ready bits stay 0.
- **Reset:**
  - State returns to IDLE and `last_grant` becomes `NUM_CONSUMERS-1`, so consumer 0 wins first.
  - All ready bits, `mem_read_valid`, `mem_read_address` and all `consumer_read_data` are cleared to 0.
- **Reset mid-operation:**
  - An outstanding memory transaction is abandoned.
  - A `mem_read_ready` arriving after reset while in IDLE is ignored.
- Requests that arrive while another grant is outstanding wait. They are considered at the next IDLE cycle.

## Timing
- Request sampled in IDLE at cycle t: `mem_read_valid` is high from t+1.
- `mem_read_ready` sampled at cycle m: `consumer_read_ready[g]` is high from m+1 and `mem_read_valid` is low from m+1.
- Best-case miss latency, from valid to the consumer's ready, is memory latency + 2 cycles.
- For a fetcher that drops valid one cycle after seeing ready, ready is high for exactly 2 cycles. The arbiter is back in IDLE 2 cycles later, and re-arbitrates on that IDLE cycle.
- Fairness: under continuous contention each consumer is served once per `NUM_CONSUMERS` grants. There is no starvation.
- Simultaneous requests in the same cycle are resolved purely by round-robin order from `last_grant+1`.

## Configuration
- **`PROG_ARB_LAST_FETCH_CACHE_EN`** defined: a one-entry cache is compiled in.
  - The cache holds `cache_valid`, `cache_addr` and `cache_data`, and is updated on every memory response.
  - In IDLE, if the granted address equals `cache_addr` and `cache_valid` is set, the arbiter skips WAITING: `consumer_read_data[g] <= cache_data`, ready is high at t+1, go to RELAYING, and `mem_read_valid` stays 0.
  - Reset clears `cache_valid`.
- Not defined: no cache logic. Every grant goes through WAITING.

## Test plan
- **Single request:** consumer 2 requests address 0x05; memory responds 0x1234 with ready 3 cycles after `mem_read_valid`. Then `mem_read_address`=0x05, `consumer_read_data[2]`=0x1234, ready on consumer 2 only, no second memory request.
- **Round-robin contention:** all 4 consumers hold valid from reset. Grants follow the order 0,1,2,3, and then 0 again after 0 re-requests. `mem_read_valid` never overlaps two grants.
- **Back-to-back on one consumer:** consumer 1 keeps valid high for 1 extra cycle after ready. The arbiter holds ready and issues exactly one memory read.
- **Reset during WAITING:** assert reset before `mem_read_ready`, then deliver a late ready. All outputs are 0 and no consumer ready is raised.
- **Cache hit (macro on):** consumer 0 fetches 0x10 → data 0xABCD, then consumer 3 fetches 0x10. Consumer 3 gets 0xABCD with ready at t+1 and `mem_read_valid` stays 0. With the macro off, the same stimulus issues a second memory read.
- **Cache invalidation (macro on):** fetch 0x10, reset, fetch 0x10 again. A memory read is issued.
